// File: rtl/ex_issue_buffer.sv
// Two-entry registered skid buffer between decode and the execute-stage ALU.
// Main slot M drives the ALU; skid slot S absorbs one cycle of backpressure.
module ex_issue_buffer #(
    parameter int N  = 64,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic [3:0]    in_alucontrol,
    input  logic [RW-1:0] in_rd,
    input  logic          in_regwrite,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_a,
    output logic [N-1:0]  out_b,
    output logic [3:0]    out_alucontrol,
    output logic [RW-1:0] out_rd,
    output logic          out_regwrite,
    output logic [1:0]    occupancy
);

    // state | meaning
    // EMPTY | M and S empty
    // ONE   | M holds the oldest op, S empty
    // TWO   | M holds the oldest op, S holds the next one
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [3:0]    alucontrol;
        logic [RW-1:0] rd;
        logic          regwrite;
    } slot_t;

    state_t state_q, state_d;
    slot_t  m_q, m_d;
    slot_t  s_q, s_d;
    slot_t  in_slot;
    logic   push;
    logic   pop;

    // Handshake outputs depend on state only, so ready never combinationally follows out_ready.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign in_slot = '{a: in_a, b: in_b, alucontrol: in_alucontrol,
                       rd: in_rd, regwrite: in_regwrite};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    m_d     = in_slot;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    m_d = in_slot;
                end else if (push) begin
                    s_d     = in_slot;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    m_d     = s_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Slot contents are left as-is; emptying the state is enough to drop them.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    assign out_a          = m_q.a;
    assign out_b          = m_q.b;
    assign out_alucontrol = m_q.alucontrol;
    assign out_rd         = m_q.rd;
    assign out_regwrite   = m_q.regwrite & out_valid;

    always_comb begin
        case (state_q)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: doc/ex_issue_buffer.md
# ex_issue_buffer

Two-entry registered skid buffer between the decode stage and the execute-stage ALU. Decode pushes one ALU operation per cycle (operands, 4-bit ALU control, destination register, write enable) via valid/ready; the buffer presents the oldest held operation directly on the ALU operand/control inputs. It absorbs one cycle of EX/MEM backpressure without a combinational ready path and supports a pipeline flush.

## Interface
- N, 64, operand width; matches the ALU data width
- RW, 5, destination register index width

- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  decode presents an operation
- in_ready  out  1  buffer accepts an operation this cycle
- in_a  in  N  first ALU operand
- in_b  in  N  second ALU operand
- in_alucontrol  in  4  ALU control code, passed through unmodified
- in_rd  in  RW  destination register index
- in_regwrite  in  1  operation writes the register file
- flush  in  1  discard every held operation and any input accepted this cycle
- out_valid  out  1  an operation is held and presented to the ALU
- out_ready  in  1  EX/MEM consumes the presented operation this cycle
- out_a, out_b  out  N  operands to the ALU
- out_alucontrol  out  4  control code to the ALU
- out_rd  out  RW  destination index
- out_regwrite  out  1  write enable; forced 0 whenever out_valid=0
- occupancy  out  2  held operations: 0, 1 or 2

## Operation
- Storage: main slot M (drives all out_* ports) and skid slot S. Each slot holds {a, b, alucontrol, rd, regwrite}.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- States:
  - EMPTY: M and S empty.
  - ONE: M full, S empty.
  - TWO: M and S full.
- in_ready = (state != TWO). out_valid = (state != EMPTY). Both depend only on state.
- Transitions, no flush:
  - EMPTY: push -> load M, ONE. Otherwise stay.
  - ONE: push & pop -> load M from input, stay ONE.
  - ONE: push & !pop -> load S, TWO.
  - ONE: !push & pop -> EMPTY.
  - ONE: neither -> hold.
  - TWO: pop -> M <= S, ONE. Otherwise hold. No push is possible.
- Order is strictly FIFO. No reordering, duplication or loss except on flush or reset.
- Flush: the next state is EMPTY regardless of push or pop.
  - A push in the same cycle is discarded.
  - A pop in the same cycle counts as consumed, because downstream sampled it.
- Data registers are not cleared on pop or flush. out_a, out_b, out_alucontrol and out_rd are don't-care while out_valid=0.
- out_regwrite = M.regwrite & out_valid, so a bubble never writes.
- No arithmetic is performed. Widths pass through unchanged.
- occupancy reads 0, 1 or 2 in EMPTY, ONE or TWO respectively.

## Timing
- Reset: sampled at the rising edge and takes priority over flush and all handshakes. After the edge with reset_n=0:
  - state EMPTY
  - out_valid=0, in_ready=1, occupancy=0
  - out_a, out_b, out_alucontrol, out_rd and out_regwrite all 0
- Reset mid-operation discards both slots. A push during the reset cycle is ignored.
- Latency: a push in EMPTY appears on out_* with out_valid=1 in the next cycle.
- Throughput: one operation per cycle while out_ready=1.
- in_ready has no combinational path from out_ready, in_valid or flush.
- All out_* are driven from registers, with no combinational input-to-output path.
- After a pop in TWO, in_ready rises in the following cycle, never in the same cycle.

## Test plan
- **Reset:** hold reset_n=0 for 2 cycles with in_valid=1, in_a=0x11.
  - Required: out_valid=0, occupancy=0, out_regwrite=0, out_a=0.
  - In the first cycle after release: in_ready=1.
- **Streaming:** out_ready=1. Push (a=5, b=3, ctl=0010, rd=7, we=1) then (a=9, b=4, ctl=0110, rd=8, we=1) in consecutive cycles.
  - Required: each appears exactly one cycle after its push, back-to-back, with occupancy=1 throughout.
- **Backpressure:** out_ready=0. Push A, B, C on consecutive cycles.
  - Required: A and B accepted, C stalls (in_ready=0, occupancy=2).
  - Then set out_ready=1. Required: A, B, C delivered in order on consecutive cycles, then occupancy=0.
- **Flush in TWO:** with out_ready=1 and in_valid=1 in the same cycle.
  - Required next cycle: out_valid=0, occupancy=0, in_ready=1. The input and S contents never appear.
- **Flush in ONE with push, out_ready=0:** required next cycle: EMPTY. A subsequent push is delivered with correct data after one cycle.
- **Bubble write-enable:** pop the last held op (we=1) with no new push.
  - Required next cycle: out_valid=0 and out_regwrite=0, while out_rd still shows the stale value.
